switch_led_responder: RTL and testbench

SWITCH_LED_RESPONDER -- requirements
Module: switch_led_responder

---
 rtl/switch_led_responder.sv | 135 +++++++++++++
 tb/tb_switch_led_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/switch_led_responder.sv
// Memory-mapped switch/LED peripheral: debounced switch input, LED output
// register and sticky status flags behind a one-cycle-latency read port.
module switch_led_responder #(
    parameter logic [15:0] DEBOUNCE_CNT = 16'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] memAddress,
    input  logic        readEnable,
    input  logic        writeEnable,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    input  logic [15:0] switches,
    output logic [15:0] leds
);

    localparam logic [29:0] ADDR_SWITCH = 30'h00000000;
    localparam logic [29:0] ADDR_LED    = 30'h00000004;
    localparam logic [29:0] ADDR_STATUS = 30'h00000008;

    logic [15:0] sync1_r;
    logic [15:0] sync2_r;
    logic [15:0] sw_stable_r;
    logic [15:0] cnt_r;
    logic [15:0] leds_r;
    logic [31:0] read_data_r;
    logic        sw_changed_r;
    logic        bus_error_r;

    logic [15:0] cnt_next_s;
    logic [16:0] cnt_inc_s;
    logic        sw_update_s;
    logic        sel_led_s;
    logic        mapped_s;
    logic        status_rd_s;
    logic        err_event_s;
    logic [31:0] read_value_s;
    logic        sw_changed_next_s;
    logic        bus_error_next_s;
    logic        unused_wdata_s;

    assign unused_wdata_s = ^writeData[31:16];
    assign readData       = read_data_r;
    assign leds           = leds_r;

    // Debounce counter: counts consecutive differing samples, accepts at the threshold.
    always_comb begin
        cnt_inc_s   = {1'b0, cnt_r} + 17'd1;
        cnt_next_s  = 16'd0;
        sw_update_s = 1'b0;
        if (sync2_r != sw_stable_r) begin
            if (cnt_inc_s == {1'b0, DEBOUNCE_CNT}) begin
                sw_update_s = 1'b1;
                cnt_next_s  = 16'd0;
            end else begin
                cnt_next_s  = cnt_inc_s[15:0];
            end
        end else begin
            cnt_next_s = 16'd0;
        end
    end

    // Address decode and read-data mux (values are the pre-edge register contents).
    always_comb begin
        read_value_s = 32'd0;
        mapped_s     = 1'b1;
        case (memAddress)
            ADDR_SWITCH: read_value_s = {16'd0, sw_stable_r};
            ADDR_LED:    read_value_s = {16'd0, leds_r};
            ADDR_STATUS: read_value_s = {30'd0, bus_error_r, sw_changed_r};
            default: begin
                read_value_s = 32'd0;
                mapped_s     = 1'b0;
            end
        endcase
        sel_led_s   = (memAddress == ADDR_LED);
        status_rd_s = readEnable && (memAddress == ADDR_STATUS);
        err_event_s = (readEnable && !mapped_s) || (writeEnable && !sel_led_s);
    end

    // Sticky flags: a set event at the same edge as a STATUS-read clear wins.
    always_comb begin
        if (sw_update_s) begin
            sw_changed_next_s = 1'b1;
        end else if (status_rd_s) begin
            sw_changed_next_s = 1'b0;
        end else begin
            sw_changed_next_s = sw_changed_r;
        end
        if (err_event_s) begin
            bus_error_next_s = 1'b1;
        end else if (status_rd_s) begin
            bus_error_next_s = 1'b0;
        end else begin
            bus_error_next_s = bus_error_r;
        end
    end

    // Switch synchronizer, debounce state and stable switch value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r     <= 16'd0;
            sync2_r     <= 16'd0;
            sw_stable_r <= 16'd0;
            cnt_r       <= 16'd0;
        end else begin
            sync1_r <= switches;
            sync2_r <= sync1_r;
            cnt_r   <= cnt_next_s;
            if (sw_update_s) begin
                sw_stable_r <= sync2_r;
            end
        end
    end

    // Bus-visible registers: read data, LEDs and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_r  <= 32'd0;
            leds_r       <= 16'd0;
            sw_changed_r <= 1'b0;
            bus_error_r  <= 1'b0;
        end else begin
            if (readEnable) begin
                read_data_r <= read_value_s;
            end
            if (writeEnable && sel_led_s) begin
                leds_r <= writeData[15:0];
            end
            sw_changed_r <= sw_changed_next_s;
            bus_error_r  <= bus_error_next_s;
        end
    end

endmodule

// File: tb/tb_switch_led_responder.sv
// Scoreboard bench for switch_led_responder: read responses are queued at
// issue time and compared by an independent monitor one edge later.
module tb_switch_led_responder;

    logic        clk;
    logic        rst;
    logic [29:0] memAddress;
    logic        readEnable;
    logic        writeEnable;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic [15:0] switches;
    logic [15:0] leds;

    int tests_run;
    int tests_failed;
    logic [31:0] exp_q[$];

    switch_led_responder #(.DEBOUNCE_CNT(16'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .memAddress (memAddress),
        .readEnable (readEnable),
        .writeEnable(writeEnable),
        .writeData  (writeData),
        .readData   (readData),
        .switches   (switches),
        .leds       (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every sampled read produces one response to compare against the queue.
    always begin
        logic re;
        logic [31:0] e;
        @(posedge clk);
        re = readEnable && !rst;
        #1;
        if (re) begin
            if (exp_q.size() == 0) begin
                check("read_unexpected", readData, 32'hDEADBEEF);
            end else begin
                e = exp_q.pop_front();
                check("read_data", readData, e);
            end
        end
    end

    task automatic rd_cyc(input logic [29:0] a, input logic [31:0] e);
        @(negedge clk);
        memAddress  = a;
        readEnable  = 1'b1;
        writeEnable = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic stop();
        @(negedge clk);
        readEnable  = 1'b0;
        writeEnable = 1'b0;
    endtask

    task automatic rd(input logic [29:0] a, input logic [31:0] e);
        rd_cyc(a, e);
        stop();
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [15:0] exp_leds);
        @(negedge clk);
        memAddress  = a;
        writeData   = d;
        writeEnable = 1'b1;
        readEnable  = 1'b0;
        @(posedge clk);
        #1;
        check("leds", {16'd0, leds}, {16'd0, exp_leds});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        memAddress   = 30'd0;
        readEnable   = 1'b0;
        writeEnable  = 1'b0;
        writeData    = 32'd0;
        switches     = 16'd0;
        #1;
        check("reset_readData", readData, 32'd0);
        check("reset_leds", {16'd0, leds}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Steady switch value accepted at the 6th edge.
        @(negedge clk);
        switches = 16'h00A5;
        repeat (5) @(posedge clk);
        rd_cyc(30'h0, 32'h00000000);
        rd_cyc(30'h0, 32'h000000A5);
        stop();
        rd(30'h8, 32'h00000001);
        rd(30'h8, 32'h00000000);

        // LED write, readback, and simultaneous read+write.
        wr(30'h4, 32'hFFFF1234, 16'h1234);
        rd(30'h4, 32'h00001234);
        @(negedge clk);
        memAddress  = 30'h4;
        readEnable  = 1'b1;
        writeEnable = 1'b1;
        writeData   = 32'h0000ABCD;
        exp_q.push_back(32'h00001234);
        @(posedge clk);
        #1;
        check("leds_rw", {16'd0, leds}, 32'h0000ABCD);
        stop();
        rd(30'h8, 32'h00000000);

        // Bus errors from unmapped read and read-only write.
        rd(30'h10, 32'h00000000);
        rd(30'h8, 32'h00000002);
        rd(30'h8, 32'h00000000);
        wr(30'h0, 32'h0000FFFF, 16'hABCD);
        stop();
        rd(30'h0, 32'h000000A5);
        rd(30'h8, 32'h00000002);
        rd(30'h8, 32'h00000000);

        // Bounce: A4 x2, A5 x2, then A4 steady; accepted at edge 10.
        for (int e = 1; e <= 11; e++) begin
            @(negedge clk);
            switches    = (e == 3 || e == 4) ? 16'h00A5 : 16'h00A4;
            memAddress  = 30'h0;
            readEnable  = 1'b1;
            writeEnable = 1'b0;
            exp_q.push_back((e <= 10) ? 32'h000000A5 : 32'h000000A4);
        end
        stop();
        rd(30'h8, 32'h00000001);

        // Master flow: two-cycle read then descending LED writes.
        @(negedge clk);
        switches = 16'd3;
        repeat (8) @(posedge clk);
        rd_cyc(30'h0, 32'd3);
        rd_cyc(30'h0, 32'd3);
        for (int i = 3; i >= 0; i--) begin
            wr(30'h4, 32'(i), 16'(i));
            check("rd_hold", readData, 32'd3);
        end
        stop();

        // Reset mid-debounce, then recovery through the normal path.
        wr(30'h4, 32'h000000FF, 16'h00FF);
        stop();
        @(negedge clk);
        switches = 16'h5555;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_leds", {16'd0, leds}, 32'd0);
        check("rst_readData", readData, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_cyc(30'h8, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_cyc(30'h0, 32'd0);
        end
        rd_cyc(30'h8, 32'd0);
        rd_cyc(30'h0, 32'h00005555);
        rd_cyc(30'h8, 32'h00000001);
        stop();

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
